reset_ctrl: RTL and testbench
=============================

# reset_ctrl

Board-level reset conditioner that generates the SoC reset from a power-on stretch and the active-low user button. Sits directly upstream of `xgsoc`: its `reset_o` drives `xgsoc.reset_i`, replacing the ad-hoc counter-plus-button OR in the board top. Adds button synchronisation, debouncing, a minimum reset pulse width and a saturating count of button-initiated resets.

## Interface
- `POR_CYCLES`, 32: cycles `reset_o` is held after `reset_i` release.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required to accept a button level change (10 ms at 12 MHz).
- `HOLD_CYCLES`, 16: minimum cycles `reset_o` stays high after the debounced button releases.
- `clk` in 1: system clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `btn_n_i` in 1: raw user button, active low, asynchronous to `clk`.
- `reset_o` out 1: registered active-high reset to the SoC.
- `btn_pressed_o` out 1: debounced button level, 1 = pressed.
- `reset_count_o` out 8: number of button-initiated resets, saturating at 255.

## Operation
- Button path: 2-FF synchroniser on `btn_n_i`, both flops reset to 1 (released). Synchronised level `s` feeds the debouncer.
- Debouncer: counter increments each cycle `s` differs from `stable`. Counter clears when `s` equals `stable`. When `s` differs and the counter equals `DEBOUNCE_CYCLES-1`, `stable <= s` and the counter clears. `btn_pressed_o = !stable`.
- FSM states: `POR`, `RUN`, `BTN_RST`, `HOLD`. A shared cycle counter, width `$clog2(max(POR_CYCLES,HOLD_CYCLES))`, serves both `POR` and `HOLD`.
  - `POR`: counts. At count `POR_CYCLES-1`, goes to `BTN_RST` if pressed, else `RUN`. This transition does not increment `reset_count_o`.
  - `RUN`: pressed -> `BTN_RST`, and `reset_count_o` increments, saturating at 255.
  - `BTN_RST`: stays while pressed. On release -> `HOLD`, counter cleared.
  - `HOLD`: pressed -> `BTN_RST` with no increment. At count `HOLD_CYCLES-1` -> `RUN`.
- `reset_o <= (next_state != RUN)`.
- `reset_i` asserted at any time, including mid-debounce or in `HOLD`:
  - `reset_o` = 1 immediately (asynchronous).
  - State = `POR`; all counters 0; synchroniser and `stable` = 1.
  - `reset_count_o` = 0.

## Timing
- Reset values: `reset_o` = 1, `btn_pressed_o` = 0, `reset_count_o` = 0.
- `reset_i` deassertion is synchronous to `clk` at the board level. `reset_o` falls on the `POR_CYCLES`-th rising edge after release.
- Press latency: `btn_n_i` held low from edge E0 (the first sampling edge).
  - `btn_pressed_o` rises at edge E0+1+`DEBOUNCE_CYCLES`.
  - `reset_o` rises one edge later.
  - `reset_count_o` updates on the same edge as `reset_o`.
- Release latency: `btn_pressed_o` falls after the same debounce delay. `reset_o` falls `HOLD_CYCLES`+1 edges after `btn_pressed_o` falls.
- Glitches shorter than `DEBOUNCE_CYCLES` after synchronisation produce no output change.
- Minimum `reset_o` high pulse for a button reset is `HOLD_CYCLES`+1 cycles.

## Configuration
- `RESET_CTRL_DEBOUNCE_EN` defined: debouncer instantiated as described.
- Undefined: `stable` = synchronised `s` directly, no debounce counter, `DEBOUNCE_CYCLES` ignored. Press latency is E0+2 for `btn_pressed_o` and E0+3 for `reset_o`. Use this for fast simulation.

## Structure
- `reset_ctrl_pkg`: FSM state enum `reset_state_t` (`POR`, `RUN`, `BTN_RST`, `HOLD`) and the `RESET_COUNT_W = 8` constant.
- Sub-module `debouncer`:
  - Parameter: `CYCLES`.
  - Ports: `clk`, `reset_i`, `d_i`, `q_o`.
  - Contains the synchroniser and the debounce counter.
  - Compiled out to the synchroniser only when `RESET_CTRL_DEBOUNCE_EN` is undefined.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=8, `POR_CYCLES`=4, `HOLD_CYCLES`=3.
- Release `reset_i`, button idle -> `reset_o` falls on the 4th edge; `reset_count_o` = 0.
- In `RUN`, hold `btn_n_i` low for 20 cycles, then high -> `reset_o` rises at E0+10, `reset_count_o` = 1, `btn_pressed_o` pulses; `reset_o` falls 4 edges after `btn_pressed_o` falls.
- In `RUN`, 5-cycle low glitch on `btn_n_i` -> no change on any output.
- Re-press during `HOLD` -> `reset_o` stays high throughout; `reset_count_o` unchanged.
- 256 full press/release sequences -> `reset_count_o` saturates at 255.
- Assert `reset_i` mid-`HOLD` with `reset_count_o` = 3 -> `reset_o` = 1 asynchronously, `reset_count_o` = 0, and the POR sequence restarts.

Source files
------------

// File: rtl/reset_ctrl_pkg.sv
// Shared types and constants for the board reset conditioner.
// The RESET_CTRL_DEBOUNCE_EN macro is consumed by debouncer.sv.
package reset_ctrl_pkg;

    localparam int unsigned RESET_COUNT_W = 8;

    typedef enum logic [1:0] {
        POR     = 2'd0,
        RUN     = 2'd1,
        BTN_RST = 2'd2,
        HOLD    = 2'd3
    } reset_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debouncer.sv
// Button synchroniser plus optional debounce filter; q_o is 1 while released.
// Define RESET_CTRL_DEBOUNCE_EN for the counting filter, otherwise sync + register only.
module debouncer
    import reset_ctrl_pkg::*;
#(
    parameter int unsigned CYCLES = 120000
) (
    input  logic clk,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic sync1;
    logic sync2;
    logic stable;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= d_i;
            sync2 <= sync1;
        end
    end

`ifdef RESET_CTRL_DEBOUNCE_EN
    localparam int unsigned CW = cnt_width(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    // A new level is accepted only after CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cnt    <= '0;
            stable <= 1'b1;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    // The debounce threshold has no effect in this build.
    localparam int unsigned UNUSED_CYCLES = CYCLES;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            stable <= 1'b1;
        end else begin
            stable <= sync2;
        end
    end
`endif

    assign q_o = stable;

endmodule

// File: rtl/reset_ctrl.sv
// Board reset conditioner: POR stretch, debounced button reset with minimum hold,
// and a saturating count of button resets. See debouncer.sv for RESET_CTRL_DEBOUNCE_EN.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int unsigned POR_CYCLES      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     btn_n_i,
    output logic                     reset_o,
    output logic                     btn_pressed_o,
    output logic [RESET_COUNT_W-1:0] reset_count_o
);

    localparam int unsigned SPAN = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW   = cnt_width(SPAN);
    localparam logic [CW-1:0] POR_LAST  = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic         stable;
    logic         pressed;
    reset_state_t state;
    reset_state_t state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic         count_inc;

    debouncer #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .reset_i(reset_i),
        .d_i    (btn_n_i),
        .q_o    (stable)
    );

    assign pressed       = ~stable;
    assign btn_pressed_o = pressed;

    // One counter serves both the POR stretch and the post-release hold.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        count_inc  = 1'b0;
        unique case (state)
            POR: begin
                if (cnt == POR_LAST) begin
                    state_next = pressed ? BTN_RST : RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (pressed) begin
                    state_next = BTN_RST;
                    count_inc  = 1'b1;
                end
            end
            BTN_RST: begin
                cnt_next = '0;
                if (!pressed) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (pressed) begin
                    state_next = BTN_RST;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = POR;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= POR;
            cnt           <= '0;
            reset_o       <= 1'b1;
            reset_count_o <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            reset_o <= (state_next != RUN);
            if (count_inc && (reset_count_o != '1)) begin
                reset_count_o <= reset_count_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl against a queue-based behavioural model.
module tb_reset_ctrl;

    localparam int DEB = 8;
    localparam int POR = 4;
    localparam int HLD = 3;
`ifdef RESET_CTRL_DEBOUNCE_EN
    localparam int DEFF = DEB;
`else
    localparam int DEFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_n = 1'b1;
    logic       reset_o;
    logic       btn_pressed_o;
    logic [7:0] reset_count_o;

    int passed = 0;
    int total  = 0;

    reset_ctrl #(
        .POR_CYCLES     (POR),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HLD)
    ) dut (
        .clk          (clk),
        .reset_i      (rst),
        .btn_n_i      (btn_n),
        .reset_o      (reset_o),
        .btn_pressed_o(btn_pressed_o),
        .reset_count_o(reset_count_o)
    );

    always #5 clk = ~clk;

    // Reference model: btn level accepted once the last DEFF synchronised
    // samples all disagree with it; reset requested while POR time remains,
    // a button reset is active, or hold time remains.
    logic m_sync1, m_sync2, m_stable, m_rst, m_pr;
    bit   win[$];
    bit   all_diff;
    bit   m_btn;
    int   m_por_left, m_hold_left, m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sync1 = 1'b1; m_sync2 = 1'b1; m_stable = 1'b1;
            win.delete();
            m_por_left = POR; m_hold_left = 0; m_btn = 0; m_cnt = 0; m_rst = 1'b1;
        end else begin
            m_pr = !m_stable;
            if (m_por_left > 0) begin
                m_por_left--;
                if (m_por_left == 0 && m_pr) m_btn = 1;
            end else if (m_btn) begin
                if (!m_pr) begin m_btn = 0; m_hold_left = HLD; end
            end else if (m_hold_left > 0) begin
                if (m_pr) begin m_btn = 1; m_hold_left = 0; end
                else m_hold_left--;
            end else if (m_pr) begin
                m_btn = 1;
                if (m_cnt < 255) m_cnt++;
            end
            m_rst = (m_por_left > 0) || m_btn || (m_hold_left > 0);
            win.push_back(m_sync2);
            if (win.size() > DEFF) void'(win.pop_front());
            all_diff = 1;
            foreach (win[i]) if (win[i] == m_stable) all_diff = 0;
            if (win.size() == DEFF && all_diff) m_stable = m_sync2;
            m_sync2 = m_sync1;
            m_sync1 = btn_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_n = 1'b1;
        repeat (3) tick();
        total++;
        if ({reset_o, btn_pressed_o, reset_count_o} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL reset_values got %b/%b/%0d want 1/0/0", reset_o, btn_pressed_o, reset_count_o);
        else passed++;
        rst = 1'b0;
        for (int k = 1; k <= POR + 2; k++) begin
            tick();
            total++;
            if (reset_o !== (k < POR))
                $display("FAIL por_release edge %0d got %b want %b", k, reset_o, (k < POR));
            else passed++;
        end
        total++;
        if (reset_count_o !== 8'd0) $display("FAIL por_count got %0d want 0", reset_count_o);
        else passed++;
    endtask

    task automatic test_press();
        int pr_fall, rs_fall;
        btn_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (btn_pressed_o !== (k >= DEFF + 1) || reset_o !== (k >= DEFF + 2))
                $display("FAIL press_latency E0+%0d got prs=%b rst=%b want prs=%b rst=%b",
                         k, btn_pressed_o, reset_o, (k >= DEFF + 1), (k >= DEFF + 2));
            else passed++;
        end
        total++;
        if (reset_count_o !== 8'd1) $display("FAIL press_count got %0d want 1", reset_count_o);
        else passed++;
        btn_n = 1'b1;
        pr_fall = -1; rs_fall = -1;
        for (int k = 0; k < 60 && rs_fall < 0; k++) begin
            tick();
            total++;
            if (reset_o !== m_rst || btn_pressed_o !== ~m_stable || reset_count_o !== 8'(m_cnt))
                $display("FAIL model_release got %b/%b/%0d want %b/%b/%0d", reset_o, btn_pressed_o,
                         reset_count_o, m_rst, ~m_stable, m_cnt);
            else passed++;
            if (pr_fall < 0 && btn_pressed_o === 1'b0) pr_fall = k;
            if (rs_fall < 0 && reset_o === 1'b0) rs_fall = k;
        end
        total++;
        if (pr_fall != DEFF + 1) $display("FAIL release_latency got %0d want %0d", pr_fall, DEFF + 1);
        else passed++;
        total++;
        if (rs_fall - pr_fall != HLD + 1)
            $display("FAIL hold_len got %0d want %0d", rs_fall - pr_fall, HLD + 1);
        else passed++;
    endtask

    task automatic test_glitch();
        int c0;
        c0 = m_cnt;
        for (int k = 0; k < 5 + 2 * DEB + 20; k++) begin
            btn_n = (k < 5) ? 1'b0 : 1'b1;
            tick();
            total++;
            if (reset_o !== m_rst || btn_pressed_o !== ~m_stable || reset_count_o !== 8'(m_cnt))
                $display("FAIL model_glitch got %b/%b/%0d want %b/%b/%0d", reset_o, btn_pressed_o,
                         reset_count_o, m_rst, ~m_stable, m_cnt);
            else passed++;
`ifdef RESET_CTRL_DEBOUNCE_EN
            total++;
            if ({reset_o, btn_pressed_o, reset_count_o} !== {1'b0, 1'b0, 8'(c0)})
                $display("FAIL glitch_quiet got %b/%b/%0d want 0/0/%0d", reset_o, btn_pressed_o,
                         reset_count_o, c0);
            else passed++;
`endif
        end
        total++;
        if (reset_o !== 1'b0 || btn_pressed_o !== 1'b0)
            $display("FAIL glitch_settle got rst=%b prs=%b want 0/0", reset_o, btn_pressed_o);
        else passed++;
    endtask

    task automatic test_rehold();
        int c_exp;
        btn_n = 1'b0;
        repeat (DEFF + 4) tick();
        c_exp = m_cnt;
        btn_n = 1'b1;
        tick();
        btn_n = 1'b0;
        for (int k = 0; k < 2 * DEFF + 6; k++) begin
            tick();
            total++;
            if (reset_o !== 1'b1 || reset_count_o !== 8'(c_exp))
                $display("FAIL rehold got rst=%b cnt=%0d want 1/%0d", reset_o, reset_count_o, c_exp);
            else passed++;
            total++;
            if (reset_o !== m_rst || btn_pressed_o !== ~m_stable || reset_count_o !== 8'(m_cnt))
                $display("FAIL model_rehold got %b/%b/%0d want %b/%b/%0d", reset_o, btn_pressed_o,
                         reset_count_o, m_rst, ~m_stable, m_cnt);
            else passed++;
        end
        btn_n = 1'b1;
        for (int k = 0; k < 100 && (reset_o !== 1'b0 || btn_pressed_o !== 1'b0); k++) tick();
        total++;
        if (reset_o !== 1'b0 || reset_count_o !== 8'(c_exp))
            $display("FAIL rehold_settle got rst=%b cnt=%0d want 0/%0d", reset_o, reset_count_o, c_exp);
        else passed++;
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 256; n++) begin
            btn_n = 1'b0;
            repeat (DEFF + 4) tick();
            btn_n = 1'b1;
            for (int k = 0; k < DEFF + HLD + 10 && reset_o !== 1'b0; k++) tick();
            total++;
            if (reset_o !== m_rst || btn_pressed_o !== ~m_stable || reset_count_o !== 8'(m_cnt))
                $display("FAIL model_sat iter %0d got %b/%b/%0d want %b/%b/%0d", n, reset_o,
                         btn_pressed_o, reset_count_o, m_rst, ~m_stable, m_cnt);
            else passed++;
        end
        total++;
        if (reset_count_o !== 8'd255) $display("FAIL saturate got %0d want 255", reset_count_o);
        else passed++;
    endtask

    task automatic test_reset_mid_hold();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (POR + 1) tick();
        for (int n = 0; n < 3; n++) begin
            btn_n = 1'b0;
            repeat (DEFF + 4) tick();
            btn_n = 1'b1;
            if (n < 2) for (int k = 0; k < DEFF + HLD + 10 && reset_o !== 1'b0; k++) tick();
        end
        for (int k = 0; k < DEFF + 10 && btn_pressed_o !== 1'b0; k++) tick();
        tick();
        total++;
        if (reset_o !== 1'b1 || reset_count_o !== 8'd3 || m_hold_left == 0)
            $display("FAIL hold_entry got rst=%b cnt=%0d hold=%0d want 1/3/>0", reset_o,
                     reset_count_o, m_hold_left);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({reset_o, btn_pressed_o, reset_count_o} !== {1'b1, 1'b0, 8'd0})
            $display("FAIL async_reset got %b/%b/%0d want 1/0/0", reset_o, btn_pressed_o, reset_count_o);
        else passed++;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= POR + 1; k++) begin
            tick();
            total++;
            if (reset_o !== (k < POR) || reset_count_o !== 8'd0)
                $display("FAIL por_restart edge %0d got rst=%b cnt=%0d want %b/0", k, reset_o,
                         reset_count_o, (k < POR));
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 40; b++) begin
            int len;
            btn_n = ~btn_n;
            len = $urandom_range(1, 2 * DEFF + 4);
            for (int k = 0; k < len; k++) begin
                tick();
                total++;
                if (reset_o !== m_rst || btn_pressed_o !== ~m_stable || reset_count_o !== 8'(m_cnt))
                    $display("FAIL model_random got %b/%b/%0d want %b/%b/%0d", reset_o, btn_pressed_o,
                             reset_count_o, m_rst, ~m_stable, m_cnt);
                else passed++;
            end
        end
        btn_n = 1'b1;
        for (int k = 0; k < 100 && (reset_o !== 1'b0 || btn_pressed_o !== 1'b0); k++) tick();
        total++;
        if (reset_o !== 1'b0 || btn_pressed_o !== 1'b0 || reset_count_o !== 8'(m_cnt))
            $display("FAIL random_settle got %b/%b/%0d want 0/0/%0d", reset_o, btn_pressed_o,
                     reset_count_o, m_cnt);
        else passed++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        test_reset();
        test_press();
        test_glitch();
        test_rehold();
        test_random();
        test_saturate();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
